minimax_bus_responder: RTL and testbench

Single-clock memory/peripheral responder for the minimax core: it sequences the core with a clock enable, arbitrates instruction fetch and data access onto one synchronous SRAM port, returns instruction halfwords and data words, and decodes the exit/status register. It sits between the minimax core and the banked SRAM. It replaces divided-clock glue with a clock-enable sequencer on one clock.

---
 rtl/minimax_resp_pkg.sv | 21 ++
 rtl/minimax_resp_mmio.sv | 58 +++++
 rtl/minimax_bus_responder.sv | 138 +++++++++++++
 tb/tb_minimax_bus_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimax_resp_pkg.sv
// Shared types and constants for the minimax bus responder: sequencer states,
// MMIO addresses and the value returned by unmapped MMIO reads.
package minimax_resp_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_ISSUE,
        ST_CAPTURE,
        ST_STEP,
        ST_HALT
    } resp_state_t;

    localparam logic [31:0] EXIT_ADDR     = 32'hFFFF_FFFC;
    localparam logic [31:0] CYCLES_OFFSET = 32'd4;
    localparam logic [31:0] MMIO_DEFAULT  = 32'h0000_0000;

    function automatic logic [15:0] select_half(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/minimax_resp_mmio.sv
// MMIO decode for the responder: sticky exit/halt register and, when
// MINIMAX_RESP_CYCLES_EN is defined, a free-running step counter at EXIT_ADDR-4.
module minimax_resp_mmio
    import minimax_resp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_issue,
`ifdef MINIMAX_RESP_CYCLES_EN
    input  logic        i_step,
`endif
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic [31:0] o_rd_value,
    output logic        o_halt,
    output logic [31:0] o_exit_code
);

    logic        r_halt;
    logic [31:0] r_exit_code;
    logic        w_exit_wr;

    // Only a full-word store to the exit address counts; partial stores are dropped.
    assign w_exit_wr = i_issue && (i_wmask == 4'hF) && (i_addr == EXIT_ADDR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_halt      <= 1'b0;
            r_exit_code <= 32'h0;
        end else if (w_exit_wr) begin
            r_halt      <= 1'b1;
            r_exit_code <= i_wdata;
        end
    end

`ifdef MINIMAX_RESP_CYCLES_EN
    localparam logic [31:0] CYCLES_ADDR = EXIT_ADDR - CYCLES_OFFSET;

    logic [31:0] r_cycles;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycles <= 32'h0;
        end else if (i_step) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign o_rd_value = (i_addr == CYCLES_ADDR) ? r_cycles : MMIO_DEFAULT;
`else
    assign o_rd_value = MMIO_DEFAULT;
`endif

    assign o_halt      = r_halt;
    assign o_exit_code = r_exit_code;

endmodule

// File: rtl/minimax_bus_responder.sv
// Clock-enable sequencer and single-port SRAM arbiter for the minimax core.
// Build option MINIMAX_RESP_CYCLES_EN adds a readable step counter in the MMIO block.
module minimax_bus_responder
    import minimax_resp_pkg::*;
#(
    parameter int PC_BITS      = 13,
    parameter int MEM_BITS     = 13,
    parameter int RESET_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                cpu_ce,
    output logic                cpu_rst,
    input  logic [PC_BITS-1:0]  inst_addr,
    output logic [15:0]         inst,
    input  logic                inst_regce,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wmask,
    input  logic                rreq,
    output logic [31:0]         rdata,
    output logic                mem_en,
    output logic [MEM_BITS-3:0] mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic [31:0]         mem_rdata,
    output logic                halt,
    output logic [31:0]         exit_code
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    resp_state_t     r_state;
    logic [RC_W-1:0] r_rst_cnt;
    logic            r_cpu_ce;
    logic            r_cpu_rst;
    logic            r_sel;
    logic            r_mmio_rd;
    logic [31:0]     r_mmio_val;
    logic [31:0]     r_rdata_q;
    logic [15:0]     r_inst_lat;
    logic [15:0]     r_inst;

    logic            w_issue;
    logic            w_data;
    logic            w_in_range;
    logic            w_mem_en;
    logic [31:0]     w_mmio_rd_value;
    logic            w_halt;

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_data     = rreq || (wmask != 4'h0);
    assign w_in_range = (({1'b0, addr} >> MEM_BITS) == 33'd0);
    assign w_mem_en   = w_issue && (!w_data || w_in_range);

    // The SRAM port is driven straight from the core's ISSUE-phase request so the
    // returned word lands in CAPTURE and reaches the core on the following STEP edge.
    assign mem_en    = w_mem_en;
    assign mem_addr  = !w_mem_en ? '0 :
                       w_data    ? (MEM_BITS-2)'(addr >> 2) :
                                   (MEM_BITS-2)'(32'(inst_addr) >> 2);
    assign mem_wmask = (w_mem_en && w_data) ? wmask : 4'h0;
    assign mem_wdata = (w_issue && w_data) ? wdata : 32'h0;

    minimax_resp_mmio u_mmio (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_issue     (w_issue),
`ifdef MINIMAX_RESP_CYCLES_EN
        .i_step      (r_state == ST_STEP),
`endif
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_wmask     (wmask),
        .o_rd_value  (w_mmio_rd_value),
        .o_halt      (w_halt),
        .o_exit_code (exit_code)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RST;
            r_rst_cnt  <= '0;
            r_cpu_ce   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_sel      <= 1'b0;
            r_mmio_rd  <= 1'b0;
            r_mmio_val <= 32'h0;
            r_rdata_q  <= 32'h0;
            r_inst_lat <= 16'h0;
            r_inst     <= 16'h0;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                        r_state   <= ST_ISSUE;
                        r_cpu_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                ST_ISSUE: begin
                    r_sel      <= w_data ? addr[1] : inst_addr[1];
                    r_mmio_rd  <= w_data && !w_in_range && (wmask == 4'h0);
                    r_mmio_val <= w_mmio_rd_value;
                    r_state    <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rdata_q  <= r_mmio_rd ? r_mmio_val : mem_rdata;
                    r_inst_lat <= select_half(mem_rdata, r_sel);
                    r_cpu_ce   <= 1'b1;
                    r_state    <= ST_STEP;
                end
                ST_STEP: begin
                    r_cpu_ce <= 1'b0;
                    if (inst_regce) begin
                        r_inst <= r_inst_lat;
                    end
                    // An exit store seen in this step's ISSUE lets the step finish, then parks.
                    r_state <= w_halt ? ST_HALT : ST_ISSUE;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RST;
                end
            endcase
        end
    end

    assign cpu_ce  = r_cpu_ce;
    assign cpu_rst = r_cpu_rst;
    assign inst    = r_inst;
    assign rdata   = r_rdata_q;
    assign halt    = w_halt;

endmodule

// File: tb/tb_minimax_bus_responder.sv
// Randomized scoreboard bench for minimax_bus_responder: the bench plays the core
// and the SRAM, and a word-level memory model predicts every step's rdata/inst.
module tb_minimax_bus_responder;
    import minimax_resp_pkg::*;

    localparam int WORDS = 2048;

    typedef struct {
        logic        chkRdata;
        logic [31:0] rdataExp;
        logic [15:0] instExp;
        int          id;
    } expect_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        cpuCe, cpuRst, instRegce, rreq, memEn, halt;
    logic [12:0] instAddr;
    logic [15:0] inst;
    logic [31:0] addr, wdata, rdata, memWdata, memRdata, exitCode;
    logic [3:0]  wmask, memWmask;
    logic [10:0] memAddr;

    logic [31:0] sram [0:WORDS-1];
    bit          sramInit = 1'b0;
    logic [31:0] refMem [0:WORDS-1];
    logic [15:0] refInst;
    int          stepsModel;
    expect_t     expQ[$];
    bit          monEn = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    int          txnId = 0;

    always #5 clk = ~clk;

    minimax_bus_responder dut (
        .clk        (clk),
        .reset      (resetN),
        .cpu_ce     (cpuCe),
        .cpu_rst    (cpuRst),
        .inst_addr  (instAddr),
        .inst       (inst),
        .inst_regce (instRegce),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .rreq       (rreq),
        .rdata      (rdata),
        .mem_en     (memEn),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_wmask  (memWmask),
        .mem_rdata  (memRdata),
        .halt       (halt),
        .exit_code  (exitCode)
    );

    function automatic logic [31:0] initWord(input int idx);
        if (idx == 1) return 32'h1234_5678;
        return (32'(idx) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] cyclesReadValue();
`ifdef MINIMAX_RESP_CYCLES_EN
        return 32'(stepsModel);
`else
        return 32'h0;
`endif
    endfunction

    // Write-first synchronous SRAM; contents are filled on the first clock edge.
    always @(posedge clk) begin
        if (!sramInit) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= initWord(i);
            sramInit <= 1'b1;
        end else if (memEn) begin
            sram[memAddr] <= mergeWord(sram[memAddr], memWdata, memWmask);
            memRdata      <= mergeWord(sram[memAddr], memWdata, memWmask);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".cpu_ce"}, 32'(cpuCe), 32'h0);
        checkOutput({tag, ".cpu_rst"}, 32'(cpuRst), 32'h1);
        checkOutput({tag, ".inst"}, 32'(inst), 32'h0);
        checkOutput({tag, ".rdata"}, rdata, 32'h0);
        checkOutput({tag, ".mem_en"}, 32'(memEn), 32'h0);
        checkOutput({tag, ".mem_addr"}, 32'(memAddr), 32'h0);
        checkOutput({tag, ".mem_wdata"}, memWdata, 32'h0);
        checkOutput({tag, ".mem_wmask"}, 32'(memWmask), 32'h0);
        checkOutput({tag, ".halt"}, 32'(halt), 32'h0);
        checkOutput({tag, ".exit_code"}, exitCode, 32'h0);
    endtask

    // Returns just after the next STEP edge, which is when a real core updates its outputs.
    task automatic waitStep();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpuCe && n < 12);
        if (!cpuCe) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL stepTimeout: no cpu_ce pulse within %0d cycles, expected one every 3", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] m, input logic [31:0] a,
                                 input logic [31:0] d, input logic [12:0] ia, input logic rc);
        expect_t     e;
        logic        isData, inRange, wordKnown, sel;
        logic [31:0] word;
        waitStep();
        rreq = r; wmask = m; addr = a; wdata = d; instAddr = ia; instRegce = rc;
        txnId++;
        isData    = r || (m != 4'h0);
        inRange   = (a < 32'(WORDS * 4));
        wordKnown = 1'b0;
        word      = 32'h0;
        sel       = 1'b0;
        e.chkRdata = 1'b1;
        e.rdataExp = 32'h0;
        if (!isData) begin
            word = refMem[ia[12:2]]; wordKnown = 1'b1; sel = ia[1];
            e.rdataExp = word;
        end else if (inRange) begin
            word = mergeWord(refMem[a[12:2]], d, m);
            refMem[a[12:2]] = word; wordKnown = 1'b1; sel = a[1];
            e.rdataExp = word;
        end else if (m == 4'h0) begin
            e.rdataExp = (a == EXIT_ADDR - 32'd4) ? cyclesReadValue() : 32'h0;
        end else begin
            e.chkRdata = 1'b0;
        end
        if (rc && wordKnown) refInst = sel ? word[31:16] : word[15:0];
        e.instExp = refInst;
        e.id      = txnId;
        expQ.push_back(e);
        stepsModel++;
        #1;
        checkOutput($sformatf("mem_en#%0d", txnId), 32'(memEn), 32'(!isData || inRange));
        if (!isData) begin
            checkOutput($sformatf("mem_addr#%0d", txnId), 32'(memAddr), 32'(ia[12:2]));
            checkOutput($sformatf("mem_wmask#%0d", txnId), 32'(memWmask), 32'h0);
        end else if (inRange) begin
            checkOutput($sformatf("mem_addr#%0d", txnId), 32'(memAddr), 32'(a[12:2]));
            checkOutput($sformatf("mem_wmask#%0d", txnId), 32'(memWmask), 32'(m));
            checkOutput($sformatf("mem_wdata#%0d", txnId), memWdata, d);
        end
    endtask

    // Called with reset asserted; releases it and checks the RST→ISSUE→CAPTURE→STEP cadence.
    task automatic startupSequence(input logic [12:0] ia);
        rreq = 1'b0; wmask = 4'h0; addr = 32'h0; wdata = 32'h0; instAddr = ia; instRegce = 1'b0;
        expQ.delete();
        refInst = 16'h0;
        stepsModel = 0;
        for (int s = 0; s < 3; s++) begin
            expQ.push_back('{chkRdata: 1'b1, rdataExp: refMem[ia[12:2]], instExp: 16'h0, id: 0});
            stepsModel++;
        end
        @(negedge clk);
        checkResetValues("inReset");
        resetN = 1'b1;
        monEn  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("cpu_rst@%0d", k + 1), 32'(cpuRst), 32'(k < 4));
            checkOutput($sformatf("cpu_ce@%0d", k + 1), 32'(cpuCe), 32'(k == 6 || k == 9 || k == 12));
            checkOutput($sformatf("mem_en@%0d", k + 1), 32'(memEn), 32'(k == 4 || k == 7 || k == 10));
        end
    endtask

    task automatic randomStep();
        int          kind, w, off;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        w    = $urandom_range(0, 15);
        off  = $urandom_range(0, 3);
        a    = 32'(w * 4 + off);
        case (kind)
            0, 1, 2, 3: applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, a[12:0], 1'($urandom_range(0, 1)));
            4, 5:       applyStimulus(1'b1, 4'h0, a, $urandom, 13'($urandom), 1'($urandom_range(0, 1)));
            6, 7:       applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a, $urandom,
                                      13'($urandom), 1'($urandom_range(0, 1)));
            8: begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h0000_8000;
                    1:       a = EXIT_ADDR - 32'd4;
                    2:       a = EXIT_ADDR;
                    default: a = 32'h0001_0000 + 32'(w * 4);
                endcase
                applyStimulus(1'b1, 4'h0, a, $urandom, 13'($urandom), 1'b0);
            end
            default: begin
                if ($urandom_range(0, 1) == 0)
                    applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 14)), EXIT_ADDR, $urandom,
                                  13'($urandom), 1'b0);
                else
                    applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 32'h8000 + 32'(w * 4),
                                  $urandom, 13'($urandom), 1'b0);
            end
        endcase
    endtask

    task automatic checkHaltedQuiet(input logic [31:0] code);
        int ceSeen = 0;
        int enSeen = 0;
        checkOutput("halt", 32'(halt), 32'h1);
        checkOutput("exit_code", exitCode, code);
        repeat (20) begin
            @(negedge clk);
            if (cpuCe) ceSeen++;
            if (memEn) enSeen++;
        end
        checkOutput("cpu_ce pulses after halt", 32'(ceSeen), 32'h0);
        checkOutput("mem_en cycles after halt", 32'(enSeen), 32'h0);
    endtask

    // Scoreboard monitor: every cpu_ce pulse is a step the core observes.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (monEn && cpuCe) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedStep: cpu_ce pulse with no pending request, expected none");
                end else begin
                    e = expQ.pop_front();
                    if (e.chkRdata) checkOutput($sformatf("rdata#%0d", e.id), rdata, e.rdataExp);
                    @(posedge clk);
                    #1;
                    checkOutput($sformatf("inst#%0d", e.id), 32'(inst), 32'(e.instExp));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) refMem[i] = initWord(i);
        rreq = 1'b0; wmask = 4'h0; addr = 32'h0; wdata = 32'h0; instAddr = 13'h0; instRegce = 1'b0;
        repeat (3) @(posedge clk);
        startupSequence(13'h0);

        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 13'h6, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 13'h4, 1'b1);
        applyStimulus(1'b0, 4'b0010, 32'h10, 32'h0000_AB00, 13'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, 13'h0, 1'b0);
        applyStimulus(1'b0, 4'hF, 32'h8000, 32'hDEAD_BEEF, 13'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h8000, 32'h0, 13'h0, 1'b0);
        applyStimulus(1'b0, 4'b0011, EXIT_ADDR, 32'h7, 13'h0, 1'b0);
        for (int n = 0; n < 40; n++) randomStep();
        checkOutput("halt before exit", 32'(halt), 32'h0);

        applyStimulus(1'b0, 4'hF, EXIT_ADDR, 32'h0, 13'h0, 1'b0);
        waitStep();
        checkHaltedQuiet(32'h0);

        monEn  = 1'b0;
        resetN = 1'b0;
        #1;
        checkResetValues("afterHalt");
        startupSequence(13'h8);
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 13'(4 * n + 2), 1'b1);

        // Drop reset in the middle of a transaction, during CAPTURE.
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 13'h6, 1'b1);
        @(posedge clk);
        #2;
        monEn  = 1'b0;
        resetN = 1'b0;
        #1;
        checkResetValues("midStep");
        startupSequence(13'h4);

        while (stepsModel < 10) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 13'h4, 1'b1);
        applyStimulus(1'b1, 4'h0, EXIT_ADDR - 32'd4, 32'h0, 13'h0, 1'b0);
        for (int n = 0; n < 10; n++) randomStep();
        applyStimulus(1'b0, 4'hF, EXIT_ADDR, 32'h7, 13'h0, 1'b0);
        waitStep();
        checkHaltedQuiet(32'h7);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
